zbuf_scheduler: RTL and testbench
=================================

Name: zbuf_scheduler

Overview:
- Owns the Z-buffer frameblock RAM ports and shares them between the drawline pixel pipeline and a background clear sweep.
- Between scanline blocks, the sweep resets every Z entry to CLEAR_VALUE while drawline accesses keep absolute priority.
- Reads of addresses the sweep has not yet reached return CLEAR_VALUE, so drawing can start before the clear finishes.
- Sits between drawline, calcline (start/done signalling) and the zbuf RAM, and runs on clk2.

Parameters:
- AW, 10, RAM address width.
- DW, 16, Z data width.
- DEPTH, 1024, entries swept per clear; DEPTH <= 2**AW.
- CLEAR_VALUE, 16'hFFFF, value written by the sweep (far plane).

Ports:
- clk2  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- draw_req  in  1  drawline access request.
- draw_we  in  1  1 = write, 0 = read; valid with draw_req.
- draw_addr  in  AW  access address.
- draw_wrdata  in  DW  write data.
- draw_gnt  out  1  access accepted this cycle.
- draw_rddata  out  DW  read result.
- draw_rdvalid  out  1  draw_rddata valid.
- clear_start  in  1  single-cycle pulse; begin sweep.
- clear_busy  out  1  sweep in progress.
- clear_done  out  1  single-cycle pulse; sweep finished.
- ram_we  out  1  RAM write enable.
- ram_wraddr  out  AW  RAM write address.
- ram_wrdata  out  DW  RAM write data.
- ram_rdaddr  out  AW  RAM read address.
- ram_rddata  in  DW  RAM read data, 1-cycle registered latency.

Behaviour:
- Reset values: all outputs 0; state IDLE; clear_ptr 0.
- RAM port outputs are combinational from the current cycle's arbitration decision.
- States:
  - IDLE: clear_start -> CLEAR, clear_ptr <= 0.
  - CLEAR: sweep active; clear_busy = 1.
- Sweep progress in CLEAR: each cycle in which no draw write is granted, the sweep writes CLEAR_VALUE at clear_ptr (ram_we = 1, ram_wraddr = clear_ptr) and clear_ptr increments.
- Sweep completion: after writing address DEPTH-1, go to IDLE and pulse clear_done for one cycle (the cycle after the last write).
- clear_start while in CLEAR restarts the sweep: clear_ptr <= 0, no clear_done for the aborted sweep.
- Draw grant (combinational, same cycle as draw_req):
  - Reads: always granted.
  - Writes: granted unless state = CLEAR and draw_addr >= clear_ptr. A stalled write holds draw_req/draw_we/draw_addr/draw_wrdata stable until granted.
  - No deadlock: stalled writes let the sweep advance, so the write is granted once clear_ptr > draw_addr.
- Granted write: ram_we = 1, ram_wraddr = draw_addr, ram_wrdata = draw_wrdata; the sweep pauses that cycle (clear_ptr holds).
- Granted read:
  - ram_rdaddr = draw_addr.
  - Bypass flag registered = (state = CLEAR && draw_addr >= clear_ptr).
  - Next cycle: draw_rdvalid = 1; draw_rddata = CLEAR_VALUE if flag else ram_rddata.
  - Read latency is exactly 1 cycle; back-to-back reads give back-to-back draw_rdvalid.
- Read and write share draw_req, so only one draw access per cycle; the RAM write port is never double-driven.
- clear_ptr width AW+1 so DEPTH = 2**AW terminates without wrap.
- Async reset mid-sweep: immediately IDLE, sweep abandoned, no clear_done.
- A clear_done pulse coinciding with a clear_start input: the pulse still asserts, and the new sweep starts.

Optional Feature:
- ZSCHED_STATS_EN
- Defined: adds output stall_count [15:0], counting cycles with draw_req & draw_we & !draw_gnt; saturates at 16'hFFFF; cleared by rst and on each clear_start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, clear_start with no draw traffic -> clear_busy high for 1024 cycles; ram_we each cycle, addresses 0..1023 with data 16'hFFFF; clear_done pulses once in cycle 1025.
- Idle (no clear), write addr 5 = 16'h1234, then read addr 5 -> draw_gnt same cycle for both; draw_rdvalid next cycle with 16'h1234.
- During sweep at clear_ptr = 100: read addr 500 -> draw_rddata 16'hFFFF without using RAM data; read addr 50 -> returns ram_rddata.
- During sweep at clear_ptr = 100: write addr 103 -> draw_gnt low for 4 cycles, then granted when clear_ptr = 104; final RAM content at 103 is the draw data.
- Continuous draw writes to addr 0 for 20 cycles mid-sweep -> clear_ptr frozen for 20 cycles; sweep total = 1024 + 20 cycles.
- clear_start at clear_ptr = 300, and a separate async rst at clear_ptr = 600 -> restart from 0 with no clear_done; reset drops clear_busy immediately with no clear_done; with ZSCHED_STATS_EN, 4 stall cycles give stall_count = 4.

Source files
------------

// File: rtl/zbuf_scheduler.sv
// Z-buffer RAM port arbiter: drawline accesses plus a background clear sweep.
// Optional ZSCHED_STATS_EN adds a saturating stalled-write cycle counter.
module zbuf_scheduler #(
  parameter int unsigned    AW          = 10,
  parameter int unsigned    DW          = 16,
  parameter int unsigned    DEPTH       = 1024,
  parameter logic [DW-1:0]  CLEAR_VALUE = 16'hFFFF
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic          draw_req,
  input  logic          draw_we,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_wrdata,
  output logic          draw_gnt,
  output logic [DW-1:0] draw_rddata,
  output logic          draw_rdvalid,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          ram_we,
  output logic [AW-1:0] ram_wraddr,
  output logic [DW-1:0] ram_wrdata,
  output logic [AW-1:0] ram_rdaddr,
  input  logic [DW-1:0] ram_rddata
`ifdef ZSCHED_STATS_EN
  ,
  output logic [15:0]   stall_count
`endif
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [AW:0] clear_ptr_q, clear_ptr_d;
  logic        rdvalid_q, rdvalid_d;
  logic        bypass_q, bypass_d;
  logic        done_q, done_d;

  logic in_clear;
  logic ahead;
  logic wr_gnt;
  logic rd_gnt;
  logic sweep_wr;

  always_comb begin
    in_clear = (state_q == CLEAR);
    // Addresses at or beyond the pointer still hold stale data logically
    ahead    = ({1'b0, draw_addr} >= clear_ptr_q);
    wr_gnt   = draw_req & draw_we & ~(in_clear & ahead);
    rd_gnt   = draw_req & ~draw_we;
    sweep_wr = in_clear & ~wr_gnt;
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    done_d      = 1'b0;
    rdvalid_d   = rd_gnt;
    bypass_d    = rd_gnt & in_clear & ahead;
    if (clear_start) begin
      state_d     = CLEAR;
      clear_ptr_d = '0;
    end else if (sweep_wr) begin
      clear_ptr_d = clear_ptr_q + 1'b1;
      if (clear_ptr_q == LAST_PTR) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clear_ptr_q <= '0;
      rdvalid_q   <= 1'b0;
      bypass_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      rdvalid_q   <= rdvalid_d;
      bypass_q    <= bypass_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    draw_gnt     = wr_gnt | rd_gnt;
    clear_busy   = in_clear;
    clear_done   = done_q;
    draw_rdvalid = rdvalid_q;
    draw_rddata  = '0;
    if (rdvalid_q) begin
      draw_rddata = bypass_q ? CLEAR_VALUE : ram_rddata;
    end
    ram_we     = wr_gnt | sweep_wr;
    ram_wraddr = wr_gnt ? draw_addr : clear_ptr_q[AW-1:0];
    ram_wrdata = wr_gnt ? draw_wrdata : CLEAR_VALUE;
    ram_rdaddr = rd_gnt ? draw_addr : '0;
  end

`ifdef ZSCHED_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stalled;

  always_comb begin
    stalled     = draw_req & draw_we & ~wr_gnt;
    stall_cnt_d = stall_cnt_q;
    if (clear_start) begin
      stall_cnt_d = '0;
    end else if (stalled && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_zbuf_scheduler.sv
// Scoreboard bench for zbuf_scheduler: logical Z-memory model plus a RAM model.
// Read results are queued at issue and checked by an independent monitor.
module tb_zbuf_scheduler;

  localparam int DEPTH = 1024;

  logic        clk2 = 1'b0;
  logic        rst = 1'b1;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [9:0]  d_addr = '0;
  logic [15:0] d_wd = '0;
  logic        d_start = 1'b0;

  logic        draw_gnt;
  logic [15:0] draw_rddata;
  logic        draw_rdvalid;
  logic        clear_busy;
  logic        clear_done;
  logic        ram_we;
  logic [9:0]  ram_wraddr;
  logic [15:0] ram_wrdata;
  logic [9:0]  ram_rdaddr;
  logic [15:0] ram_rddata = '0;
`ifdef ZSCHED_STATS_EN
  logic [15:0] stall_count;
`endif

  zbuf_scheduler dut (
    .clk2(clk2),
    .rst(rst),
    .draw_req(d_req),
    .draw_we(d_we),
    .draw_addr(d_addr),
    .draw_wrdata(d_wd),
    .draw_gnt(draw_gnt),
    .draw_rddata(draw_rddata),
    .draw_rdvalid(draw_rdvalid),
    .clear_start(d_start),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .ram_we(ram_we),
    .ram_wraddr(ram_wraddr),
    .ram_wrdata(ram_wrdata),
    .ram_rdaddr(ram_rdaddr),
    .ram_rddata(ram_rddata)
`ifdef ZSCHED_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk2 = ~clk2;

  // Physical RAM with one-cycle registered read
  logic [15:0] ram [0:DEPTH-1];
  initial foreach (ram[i]) ram[i] = '0;
  always @(posedge clk2) begin
    if (ram_we) ram[ram_wraddr] <= ram_wrdata;
    ram_rddata <= ram[ram_rdaddr];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk2) cyc <= cyc + 1;

  // Reference model: logical Z contents and sweep progress
  logic [15:0] m_mem [0:DEPTH-1];
  initial foreach (m_mem[i]) m_mem[i] = '0;
  bit m_clear = 0;
  bit m_done = 0;
  int m_ptr = 0;
  int m_stall = 0;

  typedef struct {
    logic [15:0] d;
    int          c;
  } rd_t;
  rd_t rq[$];

  bit exp_gnt;
  bit dw_gnt;
  bit sweep;

  always @(negedge clk2) begin
    if (rst) begin
      chk("rst_busy", {31'd0, clear_busy}, 0);
      chk("rst_done", {31'd0, clear_done}, 0);
      chk("rst_ram_we", {31'd0, ram_we}, 0);
      m_clear = 0;
      m_done  = 0;
      m_stall = 0;
    end else begin
      exp_gnt = d_req && (!d_we || !m_clear || int'(d_addr) < m_ptr);
      chk("gnt", {31'd0, draw_gnt}, {31'd0, exp_gnt});
      chk("busy", {31'd0, clear_busy}, {31'd0, m_clear});
      chk("done", {31'd0, clear_done}, {31'd0, m_done});
`ifdef ZSCHED_STATS_EN
      chk("stall_count", {16'd0, stall_count}, m_stall);
`endif
      dw_gnt = d_req && d_we && exp_gnt;
      sweep  = m_clear && !dw_gnt;
      chk("ram_we", {31'd0, ram_we}, {31'd0, dw_gnt || sweep});
      if (dw_gnt) begin
        chk("wr_addr", {22'd0, ram_wraddr}, {22'd0, d_addr});
        chk("wr_data", {16'd0, ram_wrdata}, {16'd0, d_wd});
        m_mem[d_addr] = d_wd;
      end else if (sweep) begin
        chk("sweep_addr", {22'd0, ram_wraddr}, m_ptr);
        chk("sweep_data", {16'd0, ram_wrdata}, 32'h0000FFFF);
        m_ptr++;
      end
      if (d_req && !d_we) begin
        chk("rd_addr", {22'd0, ram_rdaddr}, {22'd0, d_addr});
        rq.push_back('{d: m_mem[d_addr], c: cyc});
      end
      if (d_start) m_stall = 0;
      else if (d_req && d_we && !exp_gnt && m_stall < 16'hFFFF) m_stall++;
      m_done = 0;
      if (d_start) begin
        m_clear = 1;
        m_ptr   = 0;
        foreach (m_mem[i]) m_mem[i] = 16'hFFFF;
      end else if (sweep && m_ptr == DEPTH) begin
        m_clear = 0;
        m_done  = 1;
      end
    end
  end

  // Monitor: read data appears exactly one cycle after the granted read
  always @(negedge clk2) begin
    if (rst) begin
      chk("rst_rdvalid", {31'd0, draw_rdvalid}, 0);
      rq.delete();
    end else if (rq.size() > 0 && rq[0].c < cyc) begin
      rd_t e;
      e = rq.pop_front();
      chk("rdvalid", {31'd0, draw_rdvalid}, 1);
      chk("rddata", {16'd0, draw_rddata}, {16'd0, e.d});
    end else begin
      chk("rdvalid_idle", {31'd0, draw_rdvalid}, 0);
    end
  end

  task automatic step(input logic req, input logic we, input logic [9:0] a,
                      input logic [15:0] wd, input logic st);
    @(posedge clk2);
    #1;
    d_req   = req;
    d_we    = we;
    d_addr  = a;
    d_wd    = wd;
    d_start = st;
    @(negedge clk2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
  endtask

  // Stalled writes hold their request until granted
  task automatic access(input logic we, input logic [9:0] a,
                        input logic [15:0] wd, input logic st);
    int t;
    step(1, we, a, wd, st);
    t = 0;
    while (we && !draw_gnt && t < 2000) begin
      step(1, we, a, wd, 0);
      t++;
    end
    if (t == 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL write_grant_timeout: addr %h never granted", a);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (clear_busy && t < 4000) begin
      idle(1);
      t++;
    end
    idle(2);
    if (t == 4000) begin
      vectors++;
      miscompares++;
      $display("FAIL sweep_timeout: clear_busy still %b", clear_busy);
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk2);
    #1;
    rst     = 1'b1;
    d_req   = 1'b0;
    d_start = 1'b0;
    @(negedge clk2);
    @(posedge clk2);
    #1;
    rst = 1'b0;
    @(negedge clk2);
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clk2);
    @(posedge clk2);
    #1;
    rst = 1'b0;
    @(negedge clk2);

    access(1, 10'd5, 16'h1234, 0);
    access(0, 10'd5, '0, 0);
    idle(2);

    step(0, 0, '0, '0, 1);
    wait_idle();

    step(0, 0, '0, '0, 1);
    idle(100);
    access(1, 10'd103, 16'hBEEF, 0);
    access(0, 10'd500, '0, 0);
    access(0, 10'd50, '0, 0);
    access(0, 10'd103, '0, 0);
    for (int i = 0; i < 20; i++) access(1, 10'd0, 16'(i), 0);
    access(0, 10'd0, '0, 0);
    wait_idle();
    access(0, 10'd103, '0, 0);
    idle(2);

    step(0, 0, '0, '0, 1);
    idle(300);
    step(0, 0, '0, '0, 1);
    idle(600);
    pulse_rst();
    idle(3);

    step(0, 0, '0, '0, 1);
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom % 100);
      if (r < 2) step(0, 0, '0, '0, 1);
      else if (r < 35) access(0, 10'($urandom), '0, 0);
      else if (r < 55) access(1, 10'($urandom), 16'($urandom), 0);
      else idle(1);
    end
    wait_idle();
    for (int i = 0; i < 40; i++) access(0, 10'($urandom), '0, 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
